lab4_avm_cmd_master: RTL and testbench

// - Avalon-MM initiator that turns single read/write commands on a valid/ready port

---
 rtl/lab4_avm_cmd_master.sv | 118 +++++++++++
 tb/tb_lab4_avm_cmd_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lab4_avm_cmd_master.sv
// lab4_avm_cmd_master: single-outstanding Avalon-MM initiator behind a valid/ready command port.
// Define AVM_TIMEOUT_EN to abort transfers stalled by waitrequest for TIMEOUT_CYCLES cycles.
module lab4_avm_cmd_master #(
    parameter int ADDR_W         = 3,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    // Gated by reset so cmd_ready reads 0 while reset is held, not just after the edge.
    assign cmd_ready = (state == IDLE) && !reset;
`ifdef AVM_TIMEOUT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            rsp_valid     <= 1'b0;
            rsp_readdata  <= '0;
            rsp_error     <= 1'b0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (cmd_valid) begin
                        avm_address   <= cmd_address;
                        avm_write     <= cmd_write;
                        avm_read      <= !cmd_write;
                        avm_writedata <= cmd_write ? cmd_writedata : '0;
                        cnt           <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!avm_waitrequest || cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        rsp_readdata  <= (avm_read && !avm_waitrequest) ? avm_readdata : '0;
                        rsp_error     <= avm_waitrequest;
                        rsp_valid     <= 1'b1;
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        avm_address   <= '0;
                        avm_writedata <= '0;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
`else
    assign rsp_error = 1'b0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rsp_valid     <= 1'b0;
            rsp_readdata  <= '0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (cmd_valid) begin
                        avm_address   <= cmd_address;
                        avm_write     <= cmd_write;
                        avm_read      <= !cmd_write;
                        avm_writedata <= cmd_write ? cmd_writedata : '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!avm_waitrequest) begin
                        rsp_readdata  <= avm_read ? avm_readdata : '0;
                        rsp_valid     <= 1'b1;
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        avm_address   <= '0;
                        avm_writedata <= '0;
                        state         <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_lab4_avm_cmd_master.sv
// tb_lab4_avm_cmd_master: table-driven command vectors plus hand-written back-to-back, reset and timeout sequences.
module tb_lab4_avm_cmd_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_address = '0;
    logic [31:0] cmd_writedata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_readdata;
    logic        rsp_error;
    logic [2:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    lab4_avm_cmd_master #(.ADDR_W(3), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string n);
        chk({n, " avm_read"}, 32'(avm_read), 0);
        chk({n, " avm_write"}, 32'(avm_write), 0);
        chk({n, " avm_writedata"}, avm_writedata, 0);
        chk({n, " rsp_valid"}, 32'(rsp_valid), 0);
    endtask

    // Presents one command, plays the slave with `waits` stall cycles, checks the whole transfer.
    task automatic do_cmd(input vec_t v, input string n);
        @(negedge clk);
        chk({n, " ready before accept"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_address = v.addr; cmd_writedata = v.wdata;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_writedata = 32'hBAD0BAD0;
        for (int c = 0; c <= v.waits; c++) begin
            chk({n, " avm_read"}, 32'(avm_read), 32'(!v.wr));
            chk({n, " avm_write"}, 32'(avm_write), 32'(v.wr));
            chk({n, " avm_address"}, 32'(avm_address), 32'(v.addr));
            chk({n, " avm_writedata"}, avm_writedata, v.wr ? v.wdata : 32'h0);
            chk({n, " ready in access"}, 32'(cmd_ready), 0);
            chk({n, " early rsp"}, 32'(rsp_valid), 0);
            avm_waitrequest = (c < v.waits);
            avm_readdata = (c < v.waits) ? 32'hDEADBEEF : v.rdata;
            @(negedge clk);
        end
        avm_waitrequest = 1'b0; avm_readdata = 32'h0;
        chk({n, " rsp_valid"}, 32'(rsp_valid), 1);
        chk({n, " rsp_readdata"}, rsp_readdata, v.exp_rdata);
        chk({n, " rsp_error"}, 32'(rsp_error), 0);
        chk({n, " strobes dropped"}, 32'(avm_read | avm_write), 0);
        chk({n, " ready in resp"}, 32'(cmd_ready), 0);
        @(negedge clk);
        chk({n, " rsp one cycle"}, 32'(rsp_valid), 0);
        chk({n, " rsp_readdata held"}, rsp_readdata, v.exp_rdata);
        chk({n, " ready after"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{1'b1, 3'd0, 32'h000002AA, 0, 32'h00005A5A, 32'h00000000};
        vecs[1] = '{1'b0, 3'd0, 32'h11111111, 3, 32'h00000155, 32'h00000155};
        vecs[2] = '{1'b0, 3'd7, 32'h0,        0, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 3'd3, 32'hFFFFFFFF, 2, 32'h12121212, 32'h00000000};
        vecs[4] = '{1'b0, 3'd1, 32'h0,        1, 32'h00000000, 32'h00000000};
        vecs[5] = '{1'b1, 3'd7, 32'h12345678, 0, 32'h0000FFFF, 32'h00000000};

        @(negedge clk);
        chk("reset cmd_ready", 32'(cmd_ready), 0);
        chk_idle_outputs("reset");
        chk("reset rsp_readdata", rsp_readdata, 0);
        chk("reset avm_address", 32'(avm_address), 0);
        reset = 1'b0;
        #1 chk("ready after reset", 32'(cmd_ready), 1);

        for (int i = 0; i < 6; i++) do_cmd(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back writes with cmd_valid held throughout.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 3'd4; cmd_writedata = 32'h1;
        chk("b2b ready c0", 32'(cmd_ready), 1);
        @(negedge clk);
        chk("b2b ready c1", 32'(cmd_ready), 0);
        chk("b2b first addr", 32'(avm_address), 4);
        chk("b2b first write", 32'(avm_write), 1);
        cmd_address = 3'd5;
        @(negedge clk);
        chk("b2b ready c2", 32'(cmd_ready), 0);
        chk("b2b first rsp", 32'(rsp_valid), 1);
        @(negedge clk);
        chk("b2b ready c3", 32'(cmd_ready), 1);
        chk("b2b no strobe c3", 32'(avm_write), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b second addr", 32'(avm_address), 5);
        chk("b2b second write", 32'(avm_write), 1);
        chk("b2b second data", avm_writedata, 1);
        @(negedge clk);
        chk("b2b second rsp", 32'(rsp_valid), 1);

        // Reset in the middle of a stalled read.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0; avm_waitrequest = 1'b1;
        chk("rst-mid read active", 32'(avm_read), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst-mid cmd_ready", 32'(cmd_ready), 0);
        chk_idle_outputs("rst-mid");
        chk("rst-mid avm_address", 32'(avm_address), 0);
        @(negedge clk);
        reset = 1'b0; avm_waitrequest = 1'b0;
        #1 chk("rst-mid ready after", 32'(cmd_ready), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst-mid no rsp", 32'(rsp_valid), 0);
        end
        rv = '{1'b0, 3'd2, 32'h0, 1, 32'h00000ABC, 32'h00000ABC};
        do_cmd(rv, "post-reset read");

`ifdef AVM_TIMEOUT_EN
        // Read with waitrequest stuck high: aborted after 8 stall cycles.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 3'd6;
        @(negedge clk);
        cmd_valid = 1'b0; avm_waitrequest = 1'b1; avm_readdata = 32'hDEADBEEF;
        for (int c = 0; c < 8; c++) begin
            chk("tmo read held", 32'(avm_read), 1);
            chk("tmo no rsp", 32'(rsp_valid), 0);
            @(negedge clk);
        end
        chk("tmo read dropped", 32'(avm_read), 0);
        chk("tmo rsp_valid", 32'(rsp_valid), 1);
        chk("tmo rsp_error", 32'(rsp_error), 1);
        chk("tmo rsp_readdata", rsp_readdata, 0);
        avm_waitrequest = 1'b0; avm_readdata = 32'h0;
        @(negedge clk);
        chk("tmo rsp one cycle", 32'(rsp_valid), 0);
        rv = '{1'b0, 3'd6, 32'h0, 2, 32'h00000777, 32'h00000777};
        do_cmd(rv, "post-timeout read");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
